// File: rtl/multicycle_ctrl.sv
// Sequencing controller for the multicycle RV32I datapath: one FSM steps each
// instruction through fetch/decode/execute/memory/writeback and drives the datapath.
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       instr_done,
  output logic       error
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_ERROR
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_mem_wait;
  logic             w_timeout;

  logic w_mem_req, w_pcwrite, w_irwrite, w_regwrite, w_memwrite, w_done;

  // State and wait-counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign w_mem_wait = (r_state == S_FETCH) || (r_state == S_MEMREAD) ||
                      (r_state == S_MEMWRITE);
  // Last allowed cycle still completes if mem_ready arrives; only a miss there traps.
  assign w_timeout  = !mem_ready && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Next state and Moore/ready-qualified decode
  always_comb begin
    w_state_nxt = r_state;
    w_mem_req   = 1'b0;
    w_pcwrite   = 1'b0;
    w_irwrite   = 1'b0;
    w_regwrite  = 1'b0;
    w_memwrite  = 1'b0;
    w_done      = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    error       = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        w_irwrite = mem_ready;
        w_pcwrite = mem_ready;
        if (mem_ready)      w_state_nxt = S_DECODE;
        else if (w_timeout) w_state_nxt = S_ERROR;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        unique case (op)
          OP_LW, OP_SW: w_state_nxt = S_MEMADR;
          OP_R:         w_state_nxt = S_EXECR;
          OP_I:         w_state_nxt = S_EXECI;
          OP_BEQ:       w_state_nxt = S_BEQ;
          OP_JAL:       w_state_nxt = S_JAL;
          default:      w_state_nxt = S_ERROR;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        if (op == OP_LW)      w_state_nxt = S_MEMREAD;
        else if (op == OP_SW) w_state_nxt = S_MEMWRITE;
        else                  w_state_nxt = S_ERROR;
      end
      S_MEMREAD: begin
        w_mem_req = 1'b1;
        AdrSrc    = 1'b1;
        if (mem_ready)      w_state_nxt = S_MEMWB;
        else if (w_timeout) w_state_nxt = S_ERROR;
      end
      S_MEMWB: begin
        ResultSrc   = 2'b01;
        w_regwrite  = 1'b1;
        w_done      = 1'b1;
        w_state_nxt = S_FETCH;
      end
      S_MEMWRITE: begin
        w_mem_req  = 1'b1;
        AdrSrc     = 1'b1;
        w_memwrite = 1'b1;
        w_done     = mem_ready;
        if (mem_ready)      w_state_nxt = S_FETCH;
        else if (w_timeout) w_state_nxt = S_ERROR;
      end
      S_EXECR: begin
        ALUSrcA     = 2'b10;
        ALUOp       = 2'b10;
        w_state_nxt = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA     = 2'b10;
        ALUSrcB     = 2'b01;
        ALUOp       = 2'b10;
        w_state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        w_regwrite  = 1'b1;
        w_done      = 1'b1;
        w_state_nxt = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA     = 2'b10;
        ALUOp       = 2'b01;
        w_pcwrite   = zero;
        w_done      = 1'b1;
        w_state_nxt = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA     = 2'b01;
        ALUSrcB     = 2'b10;
        w_pcwrite   = 1'b1;
        w_state_nxt = S_ALUWB;
      end
      S_ERROR: error = 1'b1;
      default: w_state_nxt = S_ERROR;
    endcase

    // Counter restarts on every state change and counts unanswered memory cycles.
    if (w_state_nxt != r_state)       w_cnt_nxt = '0;
    else if (w_mem_wait && !mem_ready) w_cnt_nxt = r_cnt + CNT_W'(1);
    else                               w_cnt_nxt = r_cnt;
  end

  // Immediate format straight from the opcode
  always_comb begin
    unique case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // Strobes are forced low for as long as reset is held.
  assign mem_req    = w_mem_req  & rst_n;
  assign PCWrite    = w_pcwrite  & rst_n;
  assign IRWrite    = w_irwrite  & rst_n;
  assign RegWrite   = w_regwrite & rst_n;
  assign MemWrite   = w_memwrite & rst_n;
  assign instr_done = w_done     & rst_n;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle output signatures against hand-written
// expectations for each instruction class, stalls, timeouts, traps and reset.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
  logic       instr_done, error;

  int checks = 0;
  int errors = 0;

  multicycle_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc), .instr_done(instr_done),
    .error(error)
  );

  always #5 clk = ~clk;

  // Signature: {mem_req,PCWrite,IRWrite,RegWrite,MemWrite,AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,instr_done,error}
  localparam logic [15:0] E_RST  = {6'b000000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00};
  localparam logic [15:0] E_F1   = {6'b111000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00};
  localparam logic [15:0] E_F0   = {6'b100000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00};
  localparam logic [15:0] E_DEC  = {6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
  localparam logic [15:0] E_MADR = {6'b000000, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00};
  localparam logic [15:0] E_MRD  = {6'b100001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [15:0] E_MWB  = {6'b000100, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10};
  localparam logic [15:0] E_MWR1 = {6'b100011, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
  localparam logic [15:0] E_MWR0 = {6'b100011, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [15:0] E_EXR  = {6'b000000, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00};
  localparam logic [15:0] E_EXI  = {6'b000000, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00};
  localparam logic [15:0] E_AWB  = {6'b000100, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
  localparam logic [15:0] E_BEQ1 = {6'b010000, 2'b00, 2'b10, 2'b00, 2'b01, 2'b10};
  localparam logic [15:0] E_BEQ0 = {6'b000000, 2'b00, 2'b10, 2'b00, 2'b01, 2'b10};
  localparam logic [15:0] E_JAL  = {6'b010000, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00};
  localparam logic [15:0] E_ERR  = {6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  function automatic logic [15:0] sig();
    return {mem_req, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc,
            ResultSrc, ALUSrcA, ALUSrcB, ALUOp, instr_done, error};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs in the low phase, then check the outputs.
  task automatic cyc(input string tag, input logic rdy, input logic [15:0] exp);
    @(negedge clk);
    mem_ready = rdy;
    #1 check(tag, sig(), exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1 check("reset_strobes", sig(), E_RST);
    @(negedge clk);
    #1 check("reset_hold", sig(), E_RST);
  endtask

  // Release at a negedge and check the first FETCH cycle in the same low phase.
  task automatic release_rst(input string tag, input logic rdy, input logic [15:0] exp);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = rdy;
    #1 check(tag, sig(), exp);
  endtask

  initial begin
    rst_n = 1'b0; op = OP_R; zero = 1'b0; mem_ready = 1'b0;
    do_reset();

    // R-type add
    release_rst("r_fetch", 1'b1, E_F1);
    cyc("r_decode", 1'b1, E_DEC);
    check("r_immsrc", 16'(ImmSrc), 16'd0);
    cyc("r_execr", 1'b1, E_EXR);
    cyc("r_aluwb", 1'b1, E_AWB);

    // I-type
    op = OP_I;
    cyc("i_fetch", 1'b1, E_F1);
    cyc("i_decode", 1'b1, E_DEC);
    cyc("i_execi", 1'b1, E_EXI);
    cyc("i_aluwb", 1'b1, E_AWB);

    // LW with three stall cycles in MEMREAD
    op = OP_LW;
    cyc("lw_fetch", 1'b1, E_F1);
    cyc("lw_decode", 1'b1, E_DEC);
    check("lw_immsrc", 16'(ImmSrc), 16'd0);
    cyc("lw_memadr", 1'b1, E_MADR);
    for (int i = 0; i < 3; i++) cyc("lw_memread_stall", 1'b0, E_MRD);
    cyc("lw_memread_done", 1'b1, E_MRD);
    cyc("lw_memwb", 1'b1, E_MWB);

    // SW with one stall
    op = OP_SW;
    cyc("sw_fetch", 1'b1, E_F1);
    cyc("sw_decode", 1'b1, E_DEC);
    check("sw_immsrc", 16'(ImmSrc), 16'd1);
    cyc("sw_memadr", 1'b1, E_MADR);
    cyc("sw_memwrite_stall", 1'b0, E_MWR0);
    cyc("sw_memwrite_done", 1'b1, E_MWR1);

    // BEQ taken and not taken
    op = OP_BEQ; zero = 1'b1;
    cyc("beq1_fetch", 1'b1, E_F1);
    cyc("beq1_decode", 1'b1, E_DEC);
    check("beq_immsrc", 16'(ImmSrc), 16'd2);
    cyc("beq1_taken", 1'b1, E_BEQ1);
    zero = 1'b0;
    cyc("beq0_fetch", 1'b1, E_F1);
    cyc("beq0_decode", 1'b1, E_DEC);
    cyc("beq0_nottaken", 1'b1, E_BEQ0);

    // JAL
    op = OP_JAL;
    cyc("jal_fetch", 1'b1, E_F1);
    cyc("jal_decode", 1'b1, E_DEC);
    check("jal_immsrc", 16'(ImmSrc), 16'd3);
    cyc("jal_jal", 1'b1, E_JAL);
    cyc("jal_aluwb", 1'b1, E_AWB);

    // Ready arrives on the 16th FETCH cycle: completes normally
    op = OP_R;
    for (int i = 0; i < 15; i++) cyc("to_edge_fetch_wait", 1'b0, E_F0);
    cyc("to_edge_fetch_done", 1'b1, E_F1);
    cyc("to_edge_decode", 1'b1, E_DEC);
    cyc("to_edge_execr", 1'b1, E_EXR);
    cyc("to_edge_aluwb", 1'b1, E_AWB);

    // FETCH timeout: 16 unanswered cycles then ERROR
    for (int i = 0; i < 16; i++) cyc("to_fetch_wait", 1'b0, E_F0);
    cyc("to_error", 1'b1, E_ERR);
    cyc("to_error_sticky", 1'b1, E_ERR);
    do_reset();

    // Illegal opcode traps after DECODE
    op = 7'b1111111;
    release_rst("ill_fetch", 1'b1, E_F1);
    cyc("ill_decode", 1'b1, E_DEC);
    cyc("ill_error", 1'b1, E_ERR);
    cyc("ill_error_sticky", 1'b0, E_ERR);
    do_reset();

    // Reset dropped mid-MEMWRITE
    op = OP_SW;
    release_rst("rsw_fetch", 1'b1, E_F1);
    cyc("rsw_decode", 1'b1, E_DEC);
    cyc("rsw_memadr", 1'b1, E_MADR);
    cyc("rsw_memwrite", 1'b0, E_MWR0);
    #1 rst_n = 1'b0;
    #1 check("rsw_reset_now", sig(), E_RST);
    release_rst("rsw_after_release", 1'b1, E_F1);
    cyc("rsw_decode2", 1'b1, E_DEC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
